// File: rtl/fp_pkg.sv
// Shared IEEE-754 format helpers, operand classes and divider FSM states
// for the FP datapath (binary32/binary64, denormals flushed to zero).
package fp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_DIVIDE,
      ST_NORM,
      ST_DONE
   } fdiv_state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_t;

   localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
   localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

   function automatic int exp_w(input int n);
      return (n == 64) ? 11 : 8;
   endfunction

   function automatic int man_w(input int n);
      return (n == 64) ? 52 : 23;
   endfunction

   function automatic int bias(input int n);
      return (n == 64) ? 1023 : 127;
   endfunction

   // A zero exponent is a zero regardless of fraction (denormal flush).
   function automatic fp_class_t classify(input logic exp_zero,
                                          input logic exp_ones,
                                          input logic frac_zero);
      if (exp_zero)
         return CLS_ZERO;
      if (!exp_ones)
         return CLS_NORM;
      return frac_zero ? CLS_INF : CLS_NAN;
   endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// Start/done request bundle for the sequential FP divider.
interface fdiv_seq_if #(parameter int N = 32);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] out;
   logic         nv;
   logic         dz;
   logic         of;
   logic         uf;

   modport master (output start, a, b,
                   input  busy, done, out, nv, dz, of, uf);

   modport slave  (input  start, a, b,
                   output busy, done, out, nv, dz, of, uf);

endinterface

// File: rtl/fdiv_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MAN_W+4 steps
// counted down from load; last flags the final step.
module fdiv_mant_div #(
   parameter int MAN_W = 23
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [MAN_W-1:0] ma,
   input  logic [MAN_W-1:0] mb,
   output logic [MAN_W+3:0] quo,
   output logic             rem_nz,
   output logic             last
);

   localparam int Q_W   = MAN_W + 4;
   localparam int CNT_W = $clog2(Q_W);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Q_W - 1);

   logic [MAN_W+1:0] rem;
   logic [MAN_W:0]   div;
   logic [CNT_W-1:0] cnt;
   logic             ge;
   logic [MAN_W+1:0] rem_sub;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      ge      = (rem >= {1'b0, div});
      rem_sub = rem;
      if (ge)
         rem_sub = rem - {1'b0, div};
   end

   // NOTE: state uses non-blocking assignments so all registers update from
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         div <= '0;
         quo <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= {1'b0, 1'b1, ma};
         div <= {1'b1, mb};
         quo <= '0;
         cnt <= CNT_INIT;
      end else if (step) begin
         // rem_sub < div, so its top bit is always clear before the shift
         rem <= rem_sub << 1;
         quo <= {quo[Q_W-2:0], ge};
         cnt <= cnt - 1'b1;
      end
   end

   assign last   = (cnt == '0);
   assign rem_nz = |rem;

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 divider a/b under a start/done handshake.
// Define FDIV_RNE_EN for round-to-nearest-even; otherwise the quotient truncates.
module fdiv_seq
   import fp_pkg::*;
#(
   parameter int N = 32
) (
   input logic       clk,
   input logic       rst_n,
   fdiv_seq_if.slave bus
);

   localparam int EXP_W = exp_w(N);
   localparam int MAN_W = man_w(N);
   localparam int BIAS  = bias(N);
   localparam int E_W   = EXP_W + 2;
   localparam int Q_W   = MAN_W + 4;

   localparam logic [63:0]  QNAN_SEL = (N == 64) ? QNAN64 : {32'd0, QNAN32};
   localparam logic [N-1:0] QNAN     = QNAN_SEL[N-1:0];
   localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
   localparam logic signed [E_W-1:0] E_ZERO = '0;
   localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
   localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);

   fdiv_state_t state, state_nxt;

   logic [N-1:0]            a_q, b_q, out_q;
   logic                    nv_q, dz_q, of_q, uf_q;
   logic signed [E_W-1:0]   e_q;

   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        ma, mb;
   logic                    sign_ab;
   fp_class_t               cls_a, cls_b;
   logic [N-1:0]            inf_val;

   logic                    spec_hit, spec_nv, spec_dz;
   logic [N-1:0]            spec_val;

   logic [Q_W-1:0]          quo;
   logic                    rem_nz, div_last;

   logic [Q_W-1:0]          q_al;
   logic [MAN_W:0]          mant_pre;
   logic                    rnd_up;
   logic [MAN_W+1:0]        mant_rnd;
   logic                    carry;
   logic [MAN_W-1:0]        frac;
   logic signed [E_W-1:0]   e_n, e_f;
   logic [N-1:0]            norm_val;
   logic                    norm_of, norm_uf;

   assign ea      = a_q[N-2:MAN_W];
   assign eb      = b_q[N-2:MAN_W];
   assign ma      = a_q[MAN_W-1:0];
   assign mb      = b_q[MAN_W-1:0];
   assign sign_ab = a_q[N-1] ^ b_q[N-1];
   assign cls_a   = classify(ea == '0, &ea, ma == '0);
   assign cls_b   = classify(eb == '0, &eb, mb == '0);
   assign inf_val = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

   always_comb begin
      spec_hit = 1'b1;
      spec_nv  = 1'b0;
      spec_dz  = 1'b0;
      spec_val = '0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
          (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
         spec_val = QNAN;
         spec_nv  = 1'b1;
      end else if (cls_a == CLS_INF) begin
         spec_val = inf_val;
      end else if (cls_b == CLS_ZERO) begin
         spec_val = inf_val;
         spec_dz  = 1'b1;
      end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
         spec_val = {sign_ab, {(N-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   fdiv_mant_div #(.MAN_W(MAN_W)) u_mant_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == ST_UNPACK && !spec_hit),
      .step   (state == ST_DIVIDE),
      .ma     (ma),
      .mb     (mb),
      .quo    (quo),
      .rem_nz (rem_nz),
      .last   (div_last)
   );

   // Quotient lies in (0.5, 2): align so the hidden bit sits at the MSB.
   always_comb begin
      q_al     = quo[Q_W-1] ? quo : {quo[Q_W-2:0], 1'b0};
      e_n      = quo[Q_W-1] ? e_q : e_q - E_ONE;
      mant_pre = q_al[Q_W-1:3];
`ifdef FDIV_RNE_EN
      rnd_up   = q_al[2] & (q_al[1] | q_al[0] | rem_nz | mant_pre[0]);
`else
      rnd_up   = 1'b0;
`endif
      mant_rnd = {1'b0, mant_pre} + {{(MAN_W+1){1'b0}}, rnd_up};
      carry    = mant_rnd[MAN_W+1];
      frac     = carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
      e_f      = e_n + $signed({{(E_W-1){1'b0}}, carry});
      norm_of  = 1'b0;
      norm_uf  = 1'b0;
      norm_val = {sign_ab, e_f[EXP_W-1:0], frac};
      if (e_f >= E_MAX) begin
         norm_val = inf_val;
         norm_of  = 1'b1;
      end else if (e_f <= E_ZERO) begin
         norm_val = {sign_ab, {(N-1){1'b0}}};
         norm_uf  = 1'b1;
      end
   end

`ifndef FDIV_RNE_EN
   logic unused_grs;
   assign unused_grs = ^{q_al[2:0], rem_nz};
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (bus.start) state_nxt = ST_UNPACK;
         ST_UNPACK: state_nxt = spec_hit ? ST_DONE : ST_DIVIDE;
         ST_DIVIDE: if (div_last) state_nxt = ST_NORM;
         ST_NORM:   state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         e_q   <= '0;
         out_q <= '0;
         nv_q  <= 1'b0;
         dz_q  <= 1'b0;
         of_q  <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         if (state == ST_IDLE && bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
         end
         if (state == ST_UNPACK) begin
            e_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
            if (spec_hit) begin
               out_q <= spec_val;
               nv_q  <= spec_nv;
               dz_q  <= spec_dz;
               of_q  <= 1'b0;
               uf_q  <= 1'b0;
            end
         end
         if (state == ST_NORM) begin
            out_q <= norm_val;
            nv_q  <= 1'b0;
            dz_q  <= 1'b0;
            of_q  <= norm_of;
            uf_q  <= norm_uf;
         end
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.out  = out_q;
   assign bus.nv   = nv_q;
   assign bus.dz   = dz_q;
   assign bus.of   = of_q;
   assign bus.uf   = uf_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq (N=32): directed cases, control corners,
// and random operands against an integer-division reference model.
module tb_fdiv_seq;

   typedef struct packed {
      logic [31:0] val;
      logic        nv;
      logic        dz;
      logic        of;
      logic        uf;
   } res_t;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   fdiv_seq_if #(.N(32)) bus ();

   fdiv_seq #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic res_t mk(input logic [31:0] v, input logic nv, dz, of, uf);
      res_t r;
      r.val = v;
      r.nv  = nv;
      r.dz  = dz;
      r.of  = of;
      r.uf  = uf;
      return r;
   endfunction

   // Reference: exact integer quotient of the significands, then rounding
   // decided by comparing the remainder with half the divisor.
   function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
      res_t r;
      logic s;
      logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      longint unsigned ma1, mb1, num, sig;
      int e;
      r      = '0;
      s      = a[31] ^ b[31];
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
         return mk(32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b0);
      if (a_inf)
         return mk({s, 8'hFF, 23'd0}, 1'b0, 1'b0, 1'b0, 1'b0);
      if (b_zero)
         return mk({s, 8'hFF, 23'd0}, 1'b0, 1'b1, 1'b0, 1'b0);
      if (a_zero || b_inf)
         return mk({s, 31'd0}, 1'b0, 1'b0, 1'b0, 1'b0);
      ma1 = 64'({1'b1, a[22:0]});
      mb1 = 64'({1'b1, b[22:0]});
      e   = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (ma1 < mb1) begin
         ma1 = ma1 * 2;
         e   = e - 1;
      end
      num = ma1 << 23;
      sig = num / mb1;
`ifdef FDIV_RNE_EN
      begin
         longint unsigned rem;
         rem = num % mb1;
         if ((2 * rem > mb1) || ((2 * rem == mb1) && sig[0]))
            sig = sig + 1;
      end
`endif
      if (sig == (64'd1 << 24)) begin
         sig = 64'd1 << 23;
         e   = e + 1;
      end
      if (e >= 255)
         r = mk({s, 8'hFF, 23'd0}, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (e <= 0)
         r = mk({s, 31'd0}, 1'b0, 1'b0, 1'b0, 1'b1);
      else
         r = mk({s, 8'(e), sig[22:0]}, 1'b0, 1'b0, 1'b0, 1'b0);
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: v[30:23] = 8'h00;
         1: v[30:23] = 8'hFF;
         2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         default: ;
      endcase
      return v;
   endfunction

   // Issues one request and checks latency, result and the handshake around it.
   // poke_at > 0 pulses start (with other operands) in that cycle of the operation.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input res_t exp, input int exp_lat, input int poke_at);
      int lat;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      check({tag, " busy_first"}, 32'(bus.busy), 32'd1);
      while (!bus.done && lat < 200) begin
         @(negedge clk);
         lat++;
         bus.start = (lat == poke_at);
         if (lat == poke_at) begin
            bus.a = 32'h3F800000;
            bus.b = 32'h00000000;
         end
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " out"}, bus.out, exp.val);
      check({tag, " flags"}, 32'({bus.nv, bus.dz, bus.of, bus.uf}),
            32'({exp.nv, exp.dz, exp.of, exp.uf}));
      check({tag, " busy_done"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      res_t        rexp;
      int          n_done;
      bit          spec;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("reset out", bus.out, 32'd0);
      check("reset ctl", 32'({bus.busy, bus.done}), 32'd0);
      check("reset flags", 32'({bus.nv, bus.dz, bus.of, bus.uf}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("6/2", 32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 0), 30, 0);
      run_op("-7.5/2.5", 32'hC0F00000, 32'h40200000, mk(32'hC0400000, 0, 0, 0, 0), 30, 0);
`ifdef FDIV_RNE_EN
      run_op("1/3", 32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 0, 0, 0, 0), 30, 0);
`else
      run_op("1/3", 32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 0, 0, 0, 0), 30, 0);
`endif
      run_op("1/0", 32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 1, 0, 0), 2, 0);
      run_op("0/0", 32'h00000000, 32'h00000000, mk(32'h7FC00000, 1, 0, 0, 0), 2, 0);
      run_op("-0/2", 32'h80000000, 32'h40000000, mk(32'h80000000, 0, 0, 0, 0), 2, 0);
      run_op("inf/inf", 32'h7F800000, 32'hFF800000, mk(32'h7FC00000, 1, 0, 0, 0), 2, 0);
      run_op("3/inf", 32'h40400000, 32'hFF800000, mk(32'h80000000, 0, 0, 0, 0), 2, 0);
      run_op("ovf", 32'h7F000000, 32'h3E800000, mk(32'h7F800000, 0, 0, 1, 0), 30, 0);
      run_op("unf", 32'h00800000, 32'h40000000, mk(32'h00000000, 0, 0, 0, 1), 30, 0);

      // start during DIVIDE must be dropped, not queued
      run_op("poke", 32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 0), 30, 5);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("poke no_queue", 32'(n_done), 32'd0);
      check("poke out_hold", bus.out, 32'h40400000);

      // reset in the middle of an operation aborts it
      bus.a     = 32'h40C00000;
      bus.b     = 32'h40000000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort out", bus.out, 32'd0);
      check("abort ctl", 32'({bus.busy, bus.done}), 32'd0);
      check("abort flags", 32'({bus.nv, bus.dz, bus.of, bus.uf}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("abort no_done", 32'(n_done), 32'd0);
      run_op("after_abort", 32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 0), 30, 0);

      for (int i = 0; i < 40; i++) begin
         ra   = rand_op();
         rb   = rand_op();
         rexp = ref_div(ra, rb);
         spec = (ra[30:23] == 8'h00) || (ra[30:23] == 8'hFF) ||
                (rb[30:23] == 8'h00) || (rb[30:23] == 8'hFF);
         run_op($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb, rexp, spec ? 2 : 30, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

Sequential IEEE-754 floating-point divider. It is the inverse operation to the combinational multiplier `fmul` and shares its format rules: denormals flush to zero, and operands are binary32 or binary64 selected by `N`. It computes `a / b` with a restoring mantissa divider that retires one quotient bit per cycle, under a start/done handshake. It sits beside `fmul` in the FP datapath, where its multi-cycle latency is acceptable.

## Interface
- `N`, default 32: word width. Legal values are 32 or 64.
  - EXP_W = 8/11
  - MAN_W = 23/52
  - BIAS = 127/1023
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `a` in N: dividend. Captured on the accepted `start` edge.
- `b` in N: divisor. Captured on the accepted `start` edge.
- `busy` in/out: out 1. High whenever state is not IDLE.
- `done` out 1: one-cycle pulse; `out` and the flags are valid in that cycle.
- `out` out N: quotient. Holds until the next `done`.
- `nv` out 1: invalid flag. Set for NaN operand, 0/0 and inf/inf.
- `dz` out 1: divide-by-zero flag. Set for finite nonzero / 0.
- `of` out 1: overflow flag.
- `uf` out 1: underflow flag (result flushed to zero).

## Operation
**States:** IDLE → UNPACK → DIVIDE → NORM → DONE → IDLE. Specials go UNPACK → DONE.

**Reset:** state IDLE; `busy`, `done`, `out` and all flags are 0. Reset mid-operation aborts silently: no `done`.

**IDLE**
- `start`=1 latches `a` and `b` and moves to UNPACK.

**UNPACK:** a zero exponent is treated as zero (denormal flush). Sign = `a[N-1]^b[N-1]`. Specials:
- NaN operand, 0/0, or inf/inf: canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), `nv`=1.
- inf/finite: signed inf.
- finite nonzero / 0: signed inf, `dz`=1.
- 0/finite and finite/inf: signed zero, no flag.
- Otherwise:
  - exponent e = ea − eb + BIAS, held in a signed register EXP_W+2 wide.
  - Remainder is loaded with {1,ma}.
  - Go to DIVIDE.

**DIVIDE:** MAN_W+4 iterations, one per cycle, with a down-counter.
- Per iteration: if rem ≥ {1,mb}, then rem −= {1,mb} and shift in 1; else shift in 0. Then rem <<= 1.
- The quotient register holds MAN_W+4 bits.
- Sticky = (final rem ≠ 0).

**NORM**
- If the quotient MSB is 0: shift left one place and decrement e.
- Round (see Configuration). A mantissa carry-out increments e.
- If e ≥ 2^EXP_W−1: signed inf, `of`=1.
- If e ≤ 0: signed zero, `uf`=1.

**DONE**
- `done`=1 and `out` is registered. Flags update together with `out`.
- `start` in this cycle is ignored.

## Timing
- Accepted `start` at edge k.
- Normal operands: `done` high in cycle k+MAN_W+7, i.e. 30 cycles for N=32 and 59 for N=64.
- Specials: `done` high in cycle k+2.
- `busy` is high from k+1 through the `done` cycle inclusive. The earliest next accept is the cycle after `done`.
- `start` while `busy` is dropped, never queued.

## Configuration
- `FDIV_RNE_EN` defined: round-to-nearest-even, using guard, round and sticky; ties go to even.
- `FDIV_RNE_EN` undefined: truncate toward zero. Guard, round and sticky are discarded, and NORM never produces a mantissa carry.

## Structure
- Package `fp_pkg`:
  - `exp_w(N)`, `man_w(N)` and `bias(N)` functions.
  - `fdiv_state_t` enum.
  - Operand class enum (ZERO/NORM/INF/NAN).
  - Canonical qNaN constant.
- Sub-module `fdiv_mant_div`: the restoring iteration datapath, i.e. the remainder/quotient registers plus the counter. It has load/step/last controls and is driven by the top FSM.

## Test plan
- 6.0/2.0 (0x40C00000 / 0x40000000) → `out` 0x40400000, `done` at k+30, all flags 0.
- −7.5/2.5 (0xC0F00000 / 0x40200000) → 0xC0400000.
- 1.0/3.0 (0x3F800000 / 0x40400000) → 0x3EAAAAAB with `FDIV_RNE_EN`, 0x3EAAAAAA without.
- Specials, each with `done` at k+2:
  - 1.0/0.0 → 0x7F800000, `dz`=1.
  - 0/0 → 0x7FC00000, `nv`=1.
  - 0x80000000/2.0 → 0x80000000.
- Range limits:
  - 0x7F000000/0x3E800000 → 0x7F800000, `of`=1.
  - 0x00800000/0x40000000 → 0x00000000, `uf`=1.
- Control:
  - `start` pulsed during DIVIDE → ignored, and the original result is unchanged.
  - `rst_n` low at k+10 → no `done`, outputs 0; the following 6.0/2.0 still returns 0x40400000.
